// File: rtl/mult.sv
// Sequential 32x32 radix-2 Booth multiplier for the HI/LO unit, one step per clock.
// Optional MULT_UNSIGNED_EN adds the MultUnsigned port (33-bit zero-extended, 33 steps).
module mult (
    input  logic        clock,
    input  logic        reset,
    input  logic        MultCtrl,
    input  logic [31:0] RegAOut,
    input  logic [31:0] RegBOut,
`ifdef MULT_UNSIGNED_EN
    input  logic        MultUnsigned,
`endif
    output logic        MultDone,
    output logic [31:0] MultHIOut,
    output logic [31:0] MultLOOut
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e      r_state;
    state_e      w_state_next;

    logic [32:0] r_m;
    logic [32:0] r_acc;
    logic [32:0] r_q;
    logic        r_qm1;
    logic [5:0]  r_cnt;
    logic        r_uns;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_uns;
    logic [32:0] w_sum;
    logic [32:0] w_acc_sh;
    logic [32:0] w_q_sh;
    logic        w_last;
    logic [31:0] w_hi_final;
    logic [31:0] w_lo_final;

`ifdef MULT_UNSIGNED_EN
    assign w_uns = MultUnsigned;
`else
    assign w_uns = 1'b0;
`endif

    always_comb begin
        w_sum = r_acc;
        unique case ({r_q[0], r_qm1})
            2'b01:   w_sum = r_acc + r_m;
            2'b10:   w_sum = r_acc - r_m;
            default: w_sum = r_acc;
        endcase
    end

    // In signed mode Q is 32 bits wide, so the ACC LSB shifts into Q[31] instead of Q[32].
    assign w_acc_sh   = {w_sum[32], w_sum[32:1]};
    assign w_q_sh     = r_uns ? {w_sum[0], r_q[32:1]} : {1'b0, w_sum[0], r_q[31:1]};
    assign w_last     = (r_cnt == (r_uns ? 6'd32 : 6'd31));
    assign w_hi_final = r_uns ? {w_acc_sh[30:0], w_q_sh[32]} : w_acc_sh[31:0];
    assign w_lo_final = w_q_sh[31:0];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: if (MultCtrl) w_state_next = StRun;
            StRun: begin
                if (!MultCtrl) begin
                    w_state_next = StIdle;
                end else if (w_last) begin
                    w_state_next = StDone;
                end
            end
            StDone: if (!MultCtrl) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_m   <= '0;
            r_acc <= '0;
            r_q   <= '0;
            r_qm1 <= 1'b0;
            r_cnt <= '0;
            r_uns <= 1'b0;
            r_hi  <= '0;
            r_lo  <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (MultCtrl) begin
                        r_m   <= {RegAOut[31] & ~w_uns, RegAOut};
                        r_q   <= {1'b0, RegBOut};
                        r_qm1 <= 1'b0;
                        r_acc <= '0;
                        r_cnt <= '0;
                        r_uns <= w_uns;
                    end
                end
                StRun: begin
                    if (MultCtrl) begin
                        r_acc <= w_acc_sh;
                        r_q   <= w_q_sh;
                        r_qm1 <= r_q[0];
                        r_cnt <= r_cnt + 6'd1;
                        if (w_last) begin
                            r_hi <= w_hi_final;
                            r_lo <= w_lo_final;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        MultDone  = (r_state == StDone);
        MultHIOut = r_hi;
        MultLOOut = r_lo;
    end

endmodule

// File: tb/tb_mult.sv
// Directed self-checking bench for the Booth multiplier: latency, products, abort,
// asynchronous reset mid-run and DONE hold behaviour.
module tb_mult;

    logic        clock;
    logic        reset;
    logic        MultCtrl;
    logic [31:0] RegAOut;
    logic [31:0] RegBOut;
    logic        MultUnsigned;
    logic        MultDone;
    logic [31:0] MultHIOut;
    logic [31:0] MultLOOut;

    int errors = 0;
    int checks = 0;

    mult dut (
        .clock       (clock),
        .reset       (reset),
        .MultCtrl    (MultCtrl),
        .RegAOut     (RegAOut),
        .RegBOut     (RegBOut),
`ifdef MULT_UNSIGNED_EN
        .MultUnsigned(MultUnsigned),
`endif
        .MultDone    (MultDone),
        .MultHIOut   (MultHIOut),
        .MultLOOut   (MultLOOut)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Raise MultCtrl with operands and count edges (E0 included) until MultDone, bounded.
    task automatic do_mult(input logic [31:0] a, input logic [31:0] b, input logic uns,
                           output int edges);
        @(negedge clock);
        RegAOut      = a;
        RegBOut      = b;
        MultUnsigned = uns;
        MultCtrl     = 1'b1;
        edges        = 0;
        while (edges < 40) begin
            @(posedge clock);
            #1;
            edges++;
            if (MultDone) break;
        end
    endtask

    task automatic drop_ctrl();
        @(negedge clock);
        MultCtrl = 1'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        MultCtrl = 1'b0;
        RegAOut = 32'hDEADBEEF;
        RegBOut = 32'h12345678;
        MultUnsigned = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if (MultDone !== 1'b0) begin
            errors++; $display("FAIL reset_done got=%0b want=0", MultDone);
        end
        checks++;
        if (MultHIOut !== 32'h0) begin
            errors++; $display("FAIL reset_hi got=%h want=00000000", MultHIOut);
        end
        checks++;
        if (MultLOOut !== 32'h0) begin
            errors++; $display("FAIL reset_lo got=%h want=00000000", MultLOOut);
        end
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if (MultDone !== 1'b0) begin
            errors++; $display("FAIL idle_no_start got=%0b want=0", MultDone);
        end
    endtask

    task automatic test_signed();
        logic [31:0] va [4];
        logic [31:0] vb [4];
        logic [31:0] ehi [4];
        logic [31:0] elo [4];
        int edges;
        va[0] = 32'd7;        vb[0] = 32'd3;        ehi[0] = 32'h0;        elo[0] = 32'h15;
        va[1] = 32'hFFFFFFF9; vb[1] = 32'd3;        ehi[1] = 32'hFFFFFFFF; elo[1] = 32'hFFFFFFEB;
        va[2] = 32'h80000000; vb[2] = 32'h80000000; ehi[2] = 32'h40000000; elo[2] = 32'h0;
        va[3] = 32'hFFFFFFFF; vb[3] = 32'hFFFFFFFF; ehi[3] = 32'h0;        elo[3] = 32'h1;
        for (int i = 0; i < 4; i++) begin
            do_mult(va[i], vb[i], 1'b0, edges);
            checks++;
            if (edges !== 33 || MultDone !== 1'b1) begin
                errors++;
                $display("FAIL signed_latency[%0d] got=%0d edges done=%0b want=33", i, edges,
                         MultDone);
            end
            checks++;
            if (MultHIOut !== ehi[i]) begin
                errors++; $display("FAIL signed_hi[%0d] got=%h want=%h", i, MultHIOut, ehi[i]);
            end
            checks++;
            if (MultLOOut !== elo[i]) begin
                errors++; $display("FAIL signed_lo[%0d] got=%h want=%h", i, MultLOOut, elo[i]);
            end
            drop_ctrl();
        end
    endtask

`ifdef MULT_UNSIGNED_EN
    task automatic test_unsigned();
        int edges;
        do_mult(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, edges);
        checks++;
        if (edges !== 34) begin
            errors++; $display("FAIL unsigned_latency got=%0d want=34", edges);
        end
        checks++;
        if (MultHIOut !== 32'hFFFFFFFE) begin
            errors++; $display("FAIL unsigned_hi got=%h want=fffffffe", MultHIOut);
        end
        checks++;
        if (MultLOOut !== 32'h1) begin
            errors++; $display("FAIL unsigned_lo got=%h want=00000001", MultLOOut);
        end
        drop_ctrl();
        MultUnsigned = 1'b0;
    endtask
`endif

    task automatic test_abort();
        int  edges;
        bit  saw_done;
        do_mult(32'd5, 32'd5, 1'b0, edges);
        checks++;
        if (MultLOOut !== 32'd25 || MultHIOut !== 32'd0) begin
            errors++; $display("FAIL five_sq got=%h_%h want=0_19", MultHIOut, MultLOOut);
        end
        drop_ctrl();
        @(negedge clock);
        RegAOut  = 32'd9;
        RegBOut  = 32'd9;
        MultCtrl = 1'b1;
        repeat (6) @(posedge clock);
        @(negedge clock);
        MultCtrl = 1'b0;
        saw_done = 1'b0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (MultDone) saw_done = 1'b1;
        end
        checks++;
        if (saw_done) begin
            errors++; $display("FAIL abort_done got=1 want=0");
        end
        checks++;
        if (MultHIOut !== 32'd0 || MultLOOut !== 32'd25) begin
            errors++;
            $display("FAIL abort_hold got=%h_%h want=00000000_00000019", MultHIOut, MultLOOut);
        end
        do_mult(32'd9, 32'd9, 1'b0, edges);
        checks++;
        if (edges !== 33) begin
            errors++; $display("FAIL restart_latency got=%0d want=33", edges);
        end
        checks++;
        if (MultLOOut !== 32'd81 || MultHIOut !== 32'd0) begin
            errors++; $display("FAIL restart_val got=%h_%h want=0_51", MultHIOut, MultLOOut);
        end
        drop_ctrl();
    endtask

    task automatic test_reset_midrun();
        int edges;
        @(negedge clock);
        RegAOut  = 32'h12345678;
        RegBOut  = 32'd2;
        MultCtrl = 1'b1;
        repeat (11) @(posedge clock);
        @(negedge clock);
        #1 reset = 1'b1;
        #1;
        checks++;
        if (MultDone !== 1'b0 || MultHIOut !== 32'h0 || MultLOOut !== 32'h0) begin
            errors++;
            $display("FAIL async_reset got=%0b %h %h want=0 0 0", MultDone, MultHIOut,
                     MultLOOut);
        end
        #1 reset = 1'b0;
        edges = 0;
        while (edges < 40) begin
            @(posedge clock);
            #1;
            edges++;
            if (MultDone) break;
        end
        checks++;
        if (edges !== 33) begin
            errors++; $display("FAIL post_reset_latency got=%0d want=33", edges);
        end
        checks++;
        if (MultLOOut !== 32'h2468ACF0) begin
            errors++; $display("FAIL post_reset_lo got=%h want=2468acf0", MultLOOut);
        end
        checks++;
        if (MultHIOut !== 32'h0) begin
            errors++; $display("FAIL post_reset_hi got=%h want=00000000", MultHIOut);
        end
        drop_ctrl();
    endtask

    task automatic test_hold_done();
        int edges;
        int bad;
        do_mult(32'h00010000, 32'h00010000, 1'b0, edges);
        checks++;
        if (MultHIOut !== 32'h1 || MultLOOut !== 32'h0) begin
            errors++;
            $display("FAIL hold_val got=%h_%h want=00000001_00000000", MultHIOut, MultLOOut);
        end
        @(negedge clock);
        RegAOut = 32'h7;
        RegBOut = 32'h7;
        bad = 0;
        repeat (20) begin
            @(posedge clock);
            #1;
            if (MultDone !== 1'b1 || MultHIOut !== 32'h1 || MultLOOut !== 32'h0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL hold_stable got=%0d bad cycles want=0", bad);
        end
        drop_ctrl();
        checks++;
        if (MultDone !== 1'b0) begin
            errors++; $display("FAIL drop_done got=%0b want=0", MultDone);
        end
        checks++;
        if (MultHIOut !== 32'h1 || MultLOOut !== 32'h0) begin
            errors++; $display("FAIL idle_hold got=%h_%h want=00000001_00000000", MultHIOut,
                               MultLOOut);
        end
    endtask

    initial begin
        test_reset();
        test_signed();
`ifdef MULT_UNSIGNED_EN
        test_unsigned();
`endif
        test_abort();
        test_reset_midrun();
        test_hold_done();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
